// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: shared definitions for the 4:1 TDM receive demultiplexer.
//   - tdm_state_t : receiver FSM states (HUNT=0, RECV=1, PAR=2)
//   - NSLOT_DEF / DW_DEF : default slot count and slot width
//   - frame_len() : beats per frame, NSLOT, or NSLOT+1 when the trailing
//                   parity beat is enabled
// Build option: define TDM_PARITY_EN to append an even-parity beat to each frame.
package tdm_demux4_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } tdm_state_t;

  localparam int NSLOT_DEF = 4;
  localparam int DW_DEF    = 1;

  function automatic int frame_len(input int nslot);
`ifdef TDM_PARITY_EN
    return nslot + 1;
`else
    return nslot;
`endif
  endfunction

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_demux4_slot_ctr: slot position counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance on this cycle (an accepted beat)
//   load1      : with en, jump to 1 (slot 0 just captured on a sync beat)
//   clr        : force the count back to 0 (alignment lost)
//   cnt        : index of the next expected beat, wraps at FLEN
//   last       : cnt is the final beat of the frame
module tdm_demux4_slot_ctr #(
  parameter int FLEN = 4,
  parameter int SW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == SW'(FLEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (load1) begin
        cnt <= SW'(1);
      end else if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side TDM demultiplexer. Tracks slot position on a serial
// lane qualified by din_vld, stages each slot, and presents a complete frame on
// dout with a one-cycle dout_vld pulse. Alignment loss is flagged on sync_err.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   din        : serial slot data (DW bits per beat)
//   din_vld    : beat qualifier; idle cycles freeze everything
//   fsync      : marks slot 0 of a frame (qualified by din_vld)
//   dout       : assembled frame, slot k at [k*DW +: DW]
//   dout_vld   : one-cycle pulse with each new frame
//   slot_sel   : index of the next expected beat
//   locked     : receiver is frame-aligned
//   sync_err   : one-cycle pulse on an alignment violation
//   par_err    : one-cycle pulse on a parity mismatch (always 0 without parity)
// Build option: TDM_PARITY_EN adds a trailing even-parity beat and the PAR state.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              din,
  input  logic                       din_vld,
  input  logic                       fsync,
  output logic [NSLOT*DW-1:0]        dout,
  output logic                       dout_vld,
  output logic [$clog2(NSLOT+1)-1:0] slot_sel,
  output logic                       locked,
  output logic                       sync_err,
  output logic                       par_err
);

  localparam int SW   = $clog2(NSLOT + 1);
  localparam int FLEN = frame_len(NSLOT);

  function automatic logic [DW-1:0] xor_slots(input logic [NSLOT*DW-1:0] f);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < NSLOT; k++) p ^= f[k*DW +: DW];
    return p;
  endfunction

  tdm_state_t          state, state_nx;
  logic [NSLOT*DW-1:0] staging, stage_nx;
  logic                ctr_en, ctr_ld, ctr_clr, ctr_last;
  logic                stg_we;
  logic [SW-1:0]       stg_idx;
  logic                out_nx, serr_nx, perr_nx;

  tdm_demux4_slot_ctr #(.FLEN(FLEN), .SW(SW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load1 (ctr_ld),
    .clr   (ctr_clr),
    .cnt   (slot_sel),
    .last  (ctr_last)
  );

  assign locked = (state != HUNT);

  // Beat decode: next state, counter control, staging write, pulse requests
  always_comb begin
    state_nx = state;
    ctr_en   = 1'b0;
    ctr_ld   = 1'b0;
    ctr_clr  = 1'b0;
    stg_we   = 1'b0;
    stg_idx  = '0;
    out_nx   = 1'b0;
    serr_nx  = 1'b0;
    perr_nx  = 1'b0;
    if (din_vld) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            state_nx = RECV;
            ctr_en   = 1'b1;
            ctr_ld   = 1'b1;
            stg_we   = 1'b1;
          end
        end
        RECV: begin
          if (fsync) begin
            // Sync at slot 0 is normal; anywhere else drops the partial frame.
            ctr_en  = 1'b1;
            ctr_ld  = 1'b1;
            stg_we  = 1'b1;
            serr_nx = (slot_sel != '0);
          end else if (slot_sel == '0) begin
            serr_nx  = 1'b1;
            state_nx = HUNT;
            ctr_clr  = 1'b1;
          end else begin
            ctr_en  = 1'b1;
            stg_we  = 1'b1;
            stg_idx = slot_sel;
`ifdef TDM_PARITY_EN
            if (slot_sel == SW'(NSLOT - 1)) state_nx = PAR;
`else
            out_nx  = ctr_last;
`endif
          end
        end
`ifdef TDM_PARITY_EN
        PAR: begin
          ctr_en   = 1'b1;
          state_nx = RECV;
          if (fsync) begin
            ctr_ld  = 1'b1;
            stg_we  = 1'b1;
            serr_nx = 1'b1;
          end else begin
            out_nx  = ctr_last;
            perr_nx = ctr_last && (xor_slots(staging) != din);
          end
        end
`endif
        default: state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    stage_nx = staging;
    if (stg_we) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (stg_idx == SW'(k)) stage_nx[k*DW +: DW] = din;
      end
    end
  end

  // Register stage: FSM state, staging, output frame and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      staging  <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      sync_err <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      staging  <= stage_nx;
      dout_vld <= out_nx;
      sync_err <= serr_nx;
      par_err  <= perr_nx;
      if (out_nx) dout <= stage_nx;
    end
  end

endmodule
